// File: rtl/instr_fetch_pkg.sv
// Shared widths, PC increment, FSM encoding and alignment helper for the
// instruction fetch unit.
package instr_fetch_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } if_state_e;

    function automatic logic pc_misaligned(input logic [PC_WIDTH-1:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: FETCH -> WAIT -> FULL with redirect kill.
// Optional misaligned-redirect halt is built when IFU_MISALIGN_CHK_EN is defined.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   ibus_req_o,
    output logic [PC_WIDTH-1:0]    ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] ibus_rdata_i,
    output logic                   if_valid_o,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                   if_misalign_o
`endif
);

    if_state_e              state;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    req_pc_q;
    logic                   kill_q;
    logic                   out_valid_q;
    logic [PC_WIDTH-1:0]    out_pc_q;
    logic [INSTR_WIDTH-1:0] out_instr_q;
    logic                   halt_s;
    logic                   fetch_hs_s;

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q;
    assign halt_s        = misalign_q;
    assign if_misalign_o = misalign_q;
`else
    assign halt_s = 1'b0;
`endif

    assign ibus_req_o  = (state == ST_FETCH) && !halt_s;
    assign ibus_addr_o = pc_q;
    assign fetch_hs_s  = ibus_req_o && ibus_gnt_i;

    assign if_valid_o = out_valid_q;
    assign if_pc_o    = out_pc_q;
    assign if_instr_o = out_instr_q;

    // Control FSM: state, response-kill flag and misalignment halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            kill_q <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else if (redirect_i) begin
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q <= pc_misaligned(redirect_pc_i);
`endif
            // An accepted-but-unanswered request must still drain, so it is killed rather than abandoned.
            case (state)
                ST_FETCH: begin
                    if (fetch_hs_s) begin
                        state  <= ST_WAIT;
                        kill_q <= 1'b1;
                    end else begin
                        state  <= ST_FETCH;
                        kill_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (ibus_rvalid_i) begin
                        state  <= ST_FETCH;
                        kill_q <= 1'b0;
                    end else begin
                        state  <= ST_WAIT;
                        kill_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_FETCH;
                    kill_q <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (fetch_hs_s) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ibus_rvalid_i) begin
                        state  <= kill_q ? ST_FETCH : ST_FULL;
                        kill_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (!stall_i) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state  <= ST_FETCH;
                    kill_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: fetch PC, outstanding address and the presented instruction buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else if (redirect_i) begin
            pc_q        <= redirect_pc_i;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (fetch_hs_s) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + PC_INCR;
                    end
                end
                ST_WAIT: begin
                    if (ibus_rvalid_i && !kill_q) begin
                        out_valid_q <= 1'b1;
                        out_pc_q    <= req_pc_q;
                        out_instr_q <= ibus_rdata_i;
                    end
                end
                ST_FULL: begin
                    if (!stall_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized bus
// run checked against a transaction-level model of the expected instruction stream.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
`ifdef IFU_MISALIGN_CHK_EN
    logic        if_misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .if_misalign_o (if_misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory as seen by the bench bus model.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h1234_5678;
        ibus_gnt_i = 1'b1; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hDEAD_BEEF; stall_i = 1'b0;
        tick(); tick();
        redirect_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;
        tick();
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", if_valid_o); end
        checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc_o); end
        checks++; if (if_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_instr_o); end
        checks++; if (ibus_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got %h want 80000000", ibus_addr_o); end
`ifdef IFU_MISALIGN_CHK_EN
        checks++; if (if_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h want 0", if_misalign_o); end
`endif
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        // Stale response from before reset release must be ignored.
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0_BAD0;
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8000_0000) begin
            errors++; $display("FAIL first_req got %h/%h want 1/80000000", ibus_req_o, ibus_addr_o); end
        ibus_rvalid_i = 1'b0; ibus_gnt_i = 1'b1;
        tick();
        ibus_gnt_i = 1'b0;
        checks++; if (ibus_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
            errors++; $display("FAIL first_wait got req %h valid %h want 0/0", ibus_req_o, if_valid_o); end
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h0000_0013;
        tick();
        ibus_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0000 || if_instr_o !== 32'h0000_0013) begin
            errors++; $display("FAIL first_out got %h %h %h want 1 80000000 00000013", if_valid_o, if_pc_o, if_instr_o); end
        tick();
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8000_0004 || if_valid_o !== 1'b0) begin
            errors++; $display("FAIL next_req got %h/%h valid %h want 1/80000004/0", ibus_req_o, ibus_addr_o, if_valid_o); end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = $urandom;
        ibus_gnt_i = 1'b1; tick(); ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = d; tick(); ibus_rvalid_i = 1'b0;
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ibus_gnt_i = 1'b1;
            tick();
            checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0004 || if_instr_o !== d || ibus_req_o !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d] got %h %h %h req %h want 1 80000004 %h 0", i, if_valid_o, if_pc_o, if_instr_o, ibus_req_o, d); end
        end
        ibus_gnt_i = 1'b0; stall_i = 1'b0;
        tick();
        checks++; if (if_valid_o !== 1'b0 || ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8000_0008) begin
            errors++; $display("FAIL stall_release got %h %h %h want 0 1 80000008", if_valid_o, ibus_req_o, ibus_addr_o); end
    endtask

    task automatic test_redirect_wait();
        ibus_gnt_i = 1'b1; tick(); ibus_gnt_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100; tick(); redirect_i = 1'b0;
        checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL redir_wait_req got %h want 0", ibus_req_o); end
        tick();
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hCAFE_0001; tick(); ibus_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0 || ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8000_0100) begin
            errors++; $display("FAIL redir_wait got %h %h %h want 0 1 80000100", if_valid_o, ibus_req_o, ibus_addr_o); end
    endtask

    task automatic test_redirect_gnt();
        ibus_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200; tick();
        ibus_gnt_i = 1'b0; redirect_i = 1'b0;
        checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL redir_gnt_wait got %h want 0", ibus_req_o); end
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hCAFE_0002; tick(); ibus_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0 || ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8000_0200) begin
            errors++; $display("FAIL redir_gnt got %h %h %h want 0 1 80000200", if_valid_o, ibus_req_o, ibus_addr_o); end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; tick(); redirect_i = 1'b0;
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr got %h/%h want 1/fffffffc", ibus_req_o, ibus_addr_o); end
        ibus_gnt_i = 1'b1; tick(); ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem(32'hFFFF_FFFC); tick(); ibus_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_out got %h %h want 1 fffffffc", if_valid_o, if_pc_o); end
        tick();
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap_next got %h/%h want 1/00000000", ibus_req_o, ibus_addr_o); end
    endtask

`ifdef IFU_MISALIGN_CHK_EN
    task automatic test_misalign();
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0002; tick(); redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ibus_gnt_i = 1'b1;
            checks++; if (if_misalign_o !== 1'b1 || ibus_req_o !== 1'b0) begin
                errors++; $display("FAIL misalign_halt[%0d] got flag %h req %h want 1 0", i, if_misalign_o, ibus_req_o); end
            tick();
        end
        ibus_gnt_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0010; tick(); redirect_i = 1'b0;
        checks++; if (if_misalign_o !== 1'b0 || ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8000_0010) begin
            errors++; $display("FAIL misalign_clear got %h %h %h want 0 1 80000010", if_misalign_o, ibus_req_o, ibus_addr_o); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] fetch_pc, exp_pc, pend_addr, tgt;
        bit outstanding, ret, hs;
        int delay, consumed;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; stall_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_1000; tick(); redirect_i = 1'b0;
        fetch_pc = 32'h8000_1000; exp_pc = 32'h8000_1000;
        outstanding = 1'b0; pend_addr = 32'h0; delay = 0; consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (outstanding && ibus_req_o) begin
                checks++; errors++; $display("FAIL rand_two_outstanding cycle %0d req %h want 0", c, ibus_req_o);
            end
            redirect_i = ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            redirect_pc_i = tgt;
            ibus_gnt_i = $urandom_range(0, 1);
            stall_i = ($urandom_range(0, 2) == 0);
            ret = outstanding && (delay == 0);
            ibus_rdata_i = $urandom;
            if (ret) begin
                ibus_rvalid_i = 1'b1; ibus_rdata_i = mem(pend_addr);
            end else begin
                ibus_rvalid_i = !outstanding && ($urandom_range(0, 7) == 0);
            end
            if (ret) outstanding = 1'b0;
            else if (outstanding) delay--;
            if (ibus_req_o) begin
                checks++; if (ibus_addr_o !== fetch_pc) begin
                    errors++; $display("FAIL rand_addr cycle %0d got %h want %h", c, ibus_addr_o, fetch_pc); end
            end
            hs = ibus_req_o && ibus_gnt_i;
            if (hs) begin
                outstanding = 1'b1; pend_addr = fetch_pc; delay = $urandom_range(0, 2);
                fetch_pc = fetch_pc + 32'd4;
            end
            if (if_valid_o && !stall_i && !redirect_i) begin
                checks++; if (if_pc_o !== exp_pc || if_instr_o !== mem(exp_pc)) begin
                    errors++; $display("FAIL rand_consume cycle %0d got %h/%h want %h/%h", c, if_pc_o, if_instr_o, exp_pc, mem(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redirect_i) begin
                fetch_pc = tgt; exp_pc = tgt;
            end
            tick();
        end
        redirect_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; stall_i = 1'b0;
        checks++; if (consumed < 100) begin
            errors++; $display("FAIL rand_progress got %0d instructions want >= 100", consumed); end
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
`ifdef IFU_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
